// File: rtl/fpu_issue_ctrl_if.sv
// Request/response channel between the core and the Fpu issue controller.
// master = core side, slave = fpu_issue_ctrl.
interface fpu_issue_ctrl_if #(parameter int TAG_W = 4);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [63:0]      req_a;
  logic [63:0]      req_b;
  logic [63:0]      req_c;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [63:0]      rsp_data;
  logic             rsp_err;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid, req_op, req_a, req_b, req_c, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err, rsp_tag
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_c, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err, rsp_tag
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Issues one MAD/DIV op at a time to the Fpu, tracks the divider busy handshake
// and returns a single tagged result (with error flag) per request.
module fpu_issue_ctrl #(
  parameter int TAG_W       = 4,
  parameter int DIV_TIMEOUT = 80
) (
  input  logic        clk,
  input  logic        reset,
  fpu_issue_ctrl_if.slave bus,
  output logic        fpu_mul_div,
  output logic        fpu_neg_a,
  output logic        fpu_neg_c,
  output logic [63:0] fpu_a,
  output logic [63:0] fpu_b,
  output logic [63:0] fpu_c,
  input  logic        fpu_busy,
  input  logic [63:0] fpu_res
);
  localparam int CNT_W = $clog2(DIV_TIMEOUT + 1);
  localparam logic [63:0] SAT_POS = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SAT_NEG = 64'h8000_0000_0000_0000;

  typedef enum logic [2:0] {IDLE, MAD, DIV_LAUNCH, DIV_WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] to_cnt;
  logic             accept;
  logic             op_illegal, op_div, div_zero, timeout;
  logic [63:0]      eff_a;

  assign accept     = bus.req_valid & bus.req_ready;
  assign op_illegal = bus.req_op[2] & bus.req_op[1];
  assign op_div     = bus.req_op[2] & ~bus.req_op[1];
  assign div_zero   = (bus.req_b == 64'd0);
  // Saturation sign follows the operand after NDIV negation (most-negative wraps to itself)
  assign eff_a      = (bus.req_op == 3'd5) ? (64'd0 - bus.req_a) : bus.req_a;
  assign timeout    = (to_cnt == CNT_W'(DIV_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
        if (!bus.req_op[2])          state_nxt = MAD;
        else if (op_illegal)         state_nxt = RESP;
        else if (div_zero)           state_nxt = RESP;
        else                         state_nxt = DIV_LAUNCH;
      end
      MAD:        state_nxt = RESP;
      DIV_LAUNCH: state_nxt = DIV_WAIT;
      DIV_WAIT:   if (!fpu_busy || timeout) state_nxt = RESP;
      RESP:       if (bus.rsp_ready) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Busy gating keeps a stray (relaunched or orphaned) division from overlapping a new issue
  always_comb begin
    bus.req_ready = (state == IDLE) & ~fpu_busy & ~reset;
    bus.rsp_valid = (state == RESP) & ~reset;
    fpu_mul_div   = ((state == DIV_LAUNCH) | (state == DIV_WAIT)) & ~reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fpu_a        <= '0;
      fpu_b        <= '0;
      fpu_c        <= '0;
      fpu_neg_a    <= 1'b0;
      fpu_neg_c    <= 1'b0;
      bus.rsp_data <= '0;
      bus.rsp_err  <= 1'b0;
      bus.rsp_tag  <= '0;
      to_cnt       <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          fpu_a       <= bus.req_a;
          fpu_b       <= bus.req_b;
          fpu_c       <= bus.req_c;
          fpu_neg_a   <= (bus.req_op == 3'd2) | (bus.req_op == 3'd3) | (bus.req_op == 3'd5);
          fpu_neg_c   <= (bus.req_op == 3'd1) | (bus.req_op == 3'd3);
          bus.rsp_tag <= bus.req_tag;
          to_cnt      <= '0;
          if (op_illegal) begin
            bus.rsp_err  <= 1'b1;
            bus.rsp_data <= '0;
          end else if (op_div && div_zero) begin
            bus.rsp_err  <= 1'b1;
            bus.rsp_data <= eff_a[63] ? SAT_NEG : SAT_POS;
          end else begin
            bus.rsp_err  <= 1'b0;
          end
        end
        MAD: bus.rsp_data <= fpu_res;
        DIV_LAUNCH: to_cnt <= to_cnt + CNT_W'(1);
        DIV_WAIT: begin
          to_cnt <= to_cnt + CNT_W'(1);
          if (!fpu_busy) begin
            bus.rsp_data <= fpu_res;
          end else if (timeout) begin
            bus.rsp_err  <= 1'b1;
            bus.rsp_data <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
